axis_stim_source: RTL and testbench

Synthesizable AXI4-Stream producer that drives a kernel's input stream port (e.g. `data_in` of `shift_register`) during co-simulation and on-board bring-up. It emits a programmable-length burst of patterned beats with TLAST framing and honours TREADY back-pressure. It also measures how long the kernel refuses data, raising a sticky `blocked` flag when the consumer stalls past a limit. It is the upstream end of the stream whose consumer-side blockage the kernel deadlock monitor reports.

---
 rtl/axis_stim_source_if.sv | 32 +++
 rtl/axis_stim_source.sv | 184 ++++++++++++++++++
 tb/tb_axis_stim_source.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_stim_source_if.sv
// -----------------------------------------------------------------------------
// axis_stim_source_if
//   AXI4-Stream link between the stimulus source and the kernel input port.
//
//   Signals:
//     tdata  [DATA_WIDTH] : stream data        (master -> slave)
//     tvalid              : stream valid       (master -> slave)
//     tlast               : final beat marker  (master -> slave)
//     tready              : consumer ready     (slave  -> master)
// -----------------------------------------------------------------------------
interface axis_stim_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_stim_source.sv
// -----------------------------------------------------------------------------
// axis_stim_source
//   AXI4-Stream producer that emits a programmable-length burst of patterned
//   beats (incrementing or constant) with TLAST framing, honours back-pressure,
//   and measures how long the consumer refuses data.
//
//   Ports:
//     ap_clk, ap_rst_n : clock (rising edge), synchronous active-low reset
//     start            : launch a burst (sampled only while idle)
//     mode             : 0 = incrementing pattern, 1 = constant pattern
//     seed             : first beat value
//     length           : beats in the burst (0 = empty burst)
//     data_in          : AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//     busy             : burst in progress (SEND or DONE)
//     done             : one-cycle pulse at burst end
//     beats_sent       : handshakes completed in current/last burst
//     stall_cycles     : total stalled cycles in current/last burst (saturating)
//     blocked          : sticky, consecutive stalls reached STALL_LIMIT
// -----------------------------------------------------------------------------
module axis_stim_source #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  length,
    axis_stim_source_if.master    data_in,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beats_sent,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic                  blocked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [CNT_WIDTH-1:0]  consec_q, consec_d;
    logic                  blocked_q, blocked_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    // NOTE: every register gets a default before the case so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        pattern_d = pattern_q;
        beats_d   = beats_q;
        stall_d   = stall_q;
        consec_d  = consec_q;
        blocked_d = blocked_q;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    len_d     = length;
                    pattern_d = seed;
                    beats_d   = '0;
                    stall_d   = '0;
                    consec_d  = '0;
                    blocked_d = 1'b0;
                    if (length != '0) begin
                        state_d  = SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (length == LEN_WIDTH'(1));
                    end else begin
                        // Empty burst: skip straight to the done pulse.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            SEND: begin
                // tvalid is always high here, so tready alone decides the
                // handshake and tvalid never depends on tready.
                tvalid_d = 1'b1;
                tlast_d  = tlast_q;
                if (data_in.tready) begin
                    beats_d   = beats_q + LEN_WIDTH'(1);
                    pattern_d = mode_q ? pattern_q : pattern_q + DATA_WIDTH'(1);
                    consec_d  = '0;
                    if (tlast_q) begin
                        state_d  = DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        tlast_d = (beats_d == len_q - LEN_WIDTH'(1));
                    end
                end else begin
                    if (stall_q != CNT_MAX) begin
                        stall_d = stall_q + CNT_WIDTH'(1);
                    end
                    if (consec_q != CNT_MAX) begin
                        consec_d = consec_q + CNT_WIDTH'(1);
                    end
                    if (consec_d == LIMIT) begin
                        blocked_d = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: reset is sampled synchronously and clears every register, so all
    // outputs read zero the cycle after ap_rst_n is seen low.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            len_q     <= '0;
            pattern_q <= '0;
            beats_q   <= '0;
            stall_q   <= '0;
            consec_q  <= '0;
            blocked_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
            beats_q   <= beats_d;
            stall_q   <= stall_d;
            consec_q  <= consec_d;
            blocked_q <= blocked_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign data_in.tdata  = pattern_q;
    assign data_in.tvalid = tvalid_q;
    assign data_in.tlast  = tlast_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign beats_sent     = beats_q;
    assign stall_cycles   = stall_q;
    assign blocked        = blocked_q;

endmodule

// File: tb/tb_axis_stim_source.sv
// -----------------------------------------------------------------------------
// tb_axis_stim_source
//   Self-checking bench for axis_stim_source. A per-burst reference model
//   (expected beat index, stall totals, consecutive-stall run, sticky blocked
//   flag) predicts every output cycle by cycle from the stream rules.
// -----------------------------------------------------------------------------
module tb_axis_stim_source;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int CW    = 16;
    localparam int LIMIT = 8;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start    = 1'b0;
    logic          mode     = 1'b0;
    logic [DW-1:0] seed     = '0;
    logic [LW-1:0] length   = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] beats_sent;
    logic [CW-1:0] stall_cycles;
    logic          blocked;

    axis_stim_source_if #(.DATA_WIDTH(DW)) data_in ();

    axis_stim_source #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW),
        .STALL_LIMIT(LIMIT)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .start       (start),
        .mode        (mode),
        .seed        (seed),
        .length      (length),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .beats_sent  (beats_sent),
        .stall_cycles(stall_cycles),
        .blocked     (blocked)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state; persists between bursts for readback checks.
    int m_beats   = 0;
    int m_stall   = 0;
    int m_consec  = 0;
    bit m_blocked = 1'b0;

    // Ready stimulus: directed queue first, then random or always-ready.
    bit ready_q[$];
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit next_ready();
        if (ready_q.size() > 0) return ready_q.pop_front();
        if (rand_ready) return bit'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic run_burst(input string tag, input bit m, input logic [DW-1:0] sd,
                             input int len, input int poke_at);
        logic [DW-1:0] exp_data;
        bit            exp_done;
        bit            rdy;
        bit            fin;
        int            cyc;

        @(negedge ap_clk);
        // Previous burst's results must still be readable while idle.
        check({tag, ":idle_busy"},    busy,          64'd0);
        check({tag, ":idle_tvalid"},  data_in.tvalid, 64'd0);
        check({tag, ":idle_beats"},   beats_sent,    64'(m_beats));
        check({tag, ":idle_stall"},   stall_cycles,  64'(m_stall));
        check({tag, ":idle_blocked"}, blocked,       64'(m_blocked));

        start  = 1'b1;
        mode   = m;
        seed   = sd;
        length = LW'(len);
        m_beats   = 0;
        m_stall   = 0;
        m_consec  = 0;
        m_blocked = 1'b0;
        exp_done  = (len == 0);
        cyc = 0;
        fin = 1'b0;

        while (!fin) begin
            @(negedge ap_clk);
            cyc++;
            // Scramble the launch inputs: only the values at start count.
            start  = 1'b0;
            mode   = ~m;
            seed   = DW'($urandom());
            length = LW'($urandom());

            exp_data = m ? sd : sd + DW'(m_beats);
            check({tag, ":tvalid"}, data_in.tvalid, 64'(m_beats < len));
            if (m_beats < len) begin
                check({tag, ":tdata"}, data_in.tdata, 64'(exp_data));
                check({tag, ":tlast"}, data_in.tlast, 64'(m_beats == len - 1));
            end
            check({tag, ":done"},    done,         64'(exp_done));
            check({tag, ":busy"},    busy,         64'd1);
            check({tag, ":beats"},   beats_sent,   64'(m_beats));
            check({tag, ":stall"},   stall_cycles, 64'(m_stall));
            check({tag, ":blocked"}, blocked,      64'(m_blocked));

            if (exp_done) begin
                fin = 1'b1;
            end else if (cyc > 500) begin
                check({tag, ":timeout"}, done, 64'd1);
                fin = 1'b1;
            end
            exp_done = 1'b0;

            if (!fin && cyc == poke_at) start = 1'b1;

            if (!fin && m_beats < len) begin
                rdy = next_ready();
                data_in.tready = rdy;
                if (rdy) begin
                    m_beats++;
                    m_consec = 0;
                    if (m_beats == len) exp_done = 1'b1;
                end else begin
                    if (m_stall < (1 << CW) - 1) m_stall++;
                    if (m_consec < (1 << CW) - 1) m_consec++;
                    if (m_consec == LIMIT) m_blocked = 1'b1;
                end
            end else begin
                data_in.tready = bit'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        data_in.tready = 1'b0;

        // Reset state.
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst:tvalid",  data_in.tvalid, 64'd0);
        check("rst:tdata",   data_in.tdata,  64'd0);
        check("rst:tlast",   data_in.tlast,  64'd0);
        check("rst:busy",    busy,           64'd0);
        check("rst:done",    done,           64'd0);
        check("rst:beats",   beats_sent,     64'd0);
        check("rst:stall",   stall_cycles,   64'd0);
        check("rst:blocked", blocked,        64'd0);
        ap_rst_n = 1'b1;

        // Incrementing burst, always ready.
        run_burst("inc4", 1'b0, 32'h10, 4, 0);

        // Constant burst, ready toggling from 0.
        ready_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_burst("const3", 1'b1, 32'hA5, 3, 0);

        // Eight consecutive stalls reach the limit.
        ready_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_burst("limit", 1'b0, 32'h100, 2, 0);

        // Seven stalls, a handshake, seven stalls: never blocked.
        ready_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_burst("near_limit", 1'b0, 32'h200, 2, 0);

        // Empty burst.
        run_burst("len0", 1'b0, 32'h55, 0, 0);

        // Pattern wraps past all-ones.
        run_burst("wrap", 1'b0, 32'hFFFF_FFFF, 3, 0);

        // Start pulsed mid-burst with different inputs is ignored.
        rand_ready = 1'b1;
        run_burst("poke", 1'b0, 32'h300, 6, 2);

        // Randomized bursts with random back-pressure.
        for (int i = 0; i < 8; i++) begin
            run_burst("rand", bit'($urandom_range(0, 1)), DW'($urandom()),
                      int'($urandom_range(1, 20)), int'($urandom_range(0, 6)));
        end
        rand_ready = 1'b0;

        // Reset mid-burst abandons it without a done pulse.
        @(negedge ap_clk);
        start  = 1'b1;
        mode   = 1'b0;
        seed   = 32'h5;
        length = LW'(10);
        data_in.tready = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        @(negedge ap_clk);
        check("mid:tvalid_before", data_in.tvalid, 64'd1);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("mid:tvalid",  data_in.tvalid, 64'd0);
        check("mid:tdata",   data_in.tdata,  64'd0);
        check("mid:tlast",   data_in.tlast,  64'd0);
        check("mid:busy",    busy,           64'd0);
        check("mid:done",    done,           64'd0);
        check("mid:beats",   beats_sent,     64'd0);
        check("mid:stall",   stall_cycles,   64'd0);
        check("mid:blocked", blocked,        64'd0);
        ap_rst_n = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            check("mid:done_after",   done,           64'd0);
            check("mid:tvalid_after", data_in.tvalid, 64'd0);
        end
        m_beats   = 0;
        m_stall   = 0;
        m_blocked = 1'b0;

        // Fresh burst after the abandoned one.
        run_burst("after_rst", 1'b0, 32'h40, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
